// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch / data) arbiter onto a single shared bus.
// Data port wins ties unless the fetch port has lost STARVE_LIMIT
// arbitrations in a row. Accesses that see no ack within TIMEOUT wait
// cycles are aborted with bus_err and zero read data.
module mem_arbiter #(
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  // fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  // data port
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_sel,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  // shared bus
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err,
  // pipeline stalls
  output logic        stallreq_if,
  output logic        stallreq_mem
);

  typedef enum logic [1:0] {IDLE, IF_ACC, MEM_ACC, RESP} state_t;

  // Wait counter value on which one more missing ack means timeout.
  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic        owner_if;     // 1: current access belongs to the fetch port
  logic [7:0]  wait_cnt;
  logic [3:0]  starve_cnt;
  logic        grant_if, grant_mem, acc_ok, acc_timeout;

  // Next-state and grant/completion decode.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d     = state_q;
    grant_if    = 1'b0;
    grant_mem   = 1'b0;
    acc_ok      = 1'b0;
    acc_timeout = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (if_req && mem_req) begin
          if (starve_cnt == STARVE_MAX) grant_if  = 1'b1;
          else                          grant_mem = 1'b1;
        end else if (if_req) begin
          grant_if = 1'b1;
        end else if (mem_req) begin
          grant_mem = 1'b1;
        end
        if (grant_if)  state_d = IF_ACC;
        if (grant_mem) state_d = MEM_ACC;
      end
      IF_ACC, MEM_ACC: begin
        if (bus_ack) begin
          acc_ok  = 1'b1;
          state_d = RESP;
        end else if (wait_cnt == WAIT_LAST) begin
          acc_timeout = 1'b1;
          state_d     = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, bus latches, counters, read data and done pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_if   <= 1'b0;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_sel    <= '0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      if_done    <= 1'b0;
      mem_done   <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      bus_req <= (state_d == IF_ACC) || (state_d == MEM_ACC);

      if (grant_if) begin
        owner_if   <= 1'b1;
        bus_we     <= 1'b0;
        bus_addr   <= if_addr;
        bus_wdata  <= '0;
        bus_sel    <= 4'b1111;
        starve_cnt <= '0;
      end

      if (grant_mem) begin
        owner_if  <= 1'b0;
        bus_we    <= mem_we;
        bus_addr  <= mem_addr;
        bus_wdata <= mem_wdata;
        bus_sel   <= mem_sel;
        if (if_req && (starve_cnt != STARVE_MAX)) starve_cnt <= starve_cnt + 4'd1;
      end

      if (acc_ok || acc_timeout)                          wait_cnt <= '0;
      else if (state_q == IF_ACC || state_q == MEM_ACC)   wait_cnt <= wait_cnt + 8'd1;

      if (acc_ok || acc_timeout) begin
        if (owner_if) if_rdata  <= acc_ok ? bus_rdata : 32'd0;
        else          mem_rdata <= acc_ok ? bus_rdata : 32'd0;
      end

      if_done  <= (acc_ok || acc_timeout) && owner_if;
      mem_done <= (acc_ok || acc_timeout) && !owner_if;
      bus_err  <= acc_timeout;
    end
  end

  assign stallreq_if  = if_req  & ~if_done;
  assign stallreq_mem = mem_req & ~mem_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch-only, simultaneous requests,
// starvation relief, timeout abort, wait states and mid-access reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we, bus_ack;
  logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
  logic [3:0]  mem_sel;
  logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
  logic        if_done, mem_done, bus_req, bus_we, bus_err;
  logic [3:0]  bus_sel;
  logic        stallreq_if, stallreq_mem;

  int checks   = 0;
  int failures = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_sel(bus_sel), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 0; mem_req = 0; mem_we = 0; bus_ack = 0;
    if_addr = 0; mem_addr = 0; mem_wdata = 0; mem_sel = 0; bus_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    checks++; if ({bus_req, bus_we, if_done, mem_done, bus_err} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {bus_req, bus_we, if_done, mem_done, bus_err}); end
    checks++; if ({bus_addr, bus_wdata, bus_sel} !== 68'd0) begin
      failures++; $display("FAIL reset_bus got=%h exp=0", {bus_addr, bus_wdata, bus_sel}); end
    checks++; if ({if_rdata, mem_rdata} !== 64'd0) begin
      failures++; $display("FAIL reset_rdata got=%h exp=0", {if_rdata, mem_rdata}); end
    checks++; if ({dut.wait_cnt, dut.starve_cnt} !== 12'd0) begin
      failures++; $display("FAIL reset_counters got=%h exp=0", {dut.wait_cnt, dut.starve_cnt}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch_only();
    if_req = 1'b1; if_addr = 32'h100;                              // cycle 0
    #1;
    checks++; if (stallreq_if !== 1'b1) begin
      failures++; $display("FAIL fetch_stall_c0 got=%b exp=1", stallreq_if); end
    tick();                                                        // cycle 1
    checks++; if ({bus_req, bus_we, bus_sel, bus_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
      failures++; $display("FAIL fetch_bus_c1 got=%h exp=%h", {bus_req, bus_we, bus_sel, bus_addr},
                           {1'b1, 1'b0, 4'hF, 32'h100}); end
    checks++; if (stallreq_if !== 1'b1) begin
      failures++; $display("FAIL fetch_stall_c1 got=%b exp=1", stallreq_if); end
    bus_ack = 1'b1; bus_rdata = 32'h0050_0093;
    tick();                                                        // cycle 2
    bus_ack = 1'b0;
    checks++; if ({if_done, mem_done, bus_err, bus_req} !== 4'b1000) begin
      failures++; $display("FAIL fetch_done_c2 got=%b exp=1000", {if_done, mem_done, bus_err, bus_req}); end
    checks++; if (if_rdata !== 32'h0050_0093) begin
      failures++; $display("FAIL fetch_rdata got=%h exp=00500093", if_rdata); end
    checks++; if (stallreq_if !== 1'b0) begin
      failures++; $display("FAIL fetch_stall_c2 got=%b exp=0", stallreq_if); end
    if_req = 1'b0;
    tick();                                                        // cycle 3
    checks++; if ({if_done, bus_req} !== 2'b00) begin
      failures++; $display("FAIL fetch_idle_c3 got=%b exp=00", {if_done, bus_req}); end
  endtask

  task automatic test_simultaneous();
    if_req = 1'b1; if_addr = 32'h104;                              // cycle 0
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h2000; mem_wdata = 32'hDEAD_BEEF; mem_sel = 4'hF;
    tick();                                                        // cycle 1
    checks++; if ({bus_req, bus_we, bus_sel, bus_addr, bus_wdata} !== {1'b1, 1'b1, 4'hF, 32'h2000, 32'hDEAD_BEEF}) begin
      failures++; $display("FAIL simul_mem_bus got=%h exp=%h", {bus_req, bus_we, bus_sel, bus_addr, bus_wdata},
                           {1'b1, 1'b1, 4'hF, 32'h2000, 32'hDEAD_BEEF}); end
    bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
    tick();                                                        // cycle 2
    bus_ack = 1'b0;
    checks++; if ({mem_done, if_done, bus_err} !== 3'b100) begin
      failures++; $display("FAIL simul_mem_done got=%b exp=100", {mem_done, if_done, bus_err}); end
    checks++; if (dut.starve_cnt !== 4'd1) begin
      failures++; $display("FAIL simul_starve got=%0d exp=1", dut.starve_cnt); end
    mem_req = 1'b0; mem_we = 1'b0;
    tick();                                                        // cycle 3
    checks++; if (bus_req !== 1'b0) begin
      failures++; $display("FAIL simul_idle got=%b exp=0", bus_req); end
    tick();                                                        // cycle 4
    checks++; if ({bus_req, bus_we, bus_sel, bus_addr} !== {1'b1, 1'b0, 4'hF, 32'h104}) begin
      failures++; $display("FAIL simul_if_bus got=%h exp=%h", {bus_req, bus_we, bus_sel, bus_addr},
                           {1'b1, 1'b0, 4'hF, 32'h104}); end
    bus_ack = 1'b1; bus_rdata = 32'h0000_0013;
    tick();                                                        // cycle 5
    bus_ack = 1'b0;
    checks++; if ({if_done, mem_done, if_rdata} !== {2'b10, 32'h0000_0013}) begin
      failures++; $display("FAIL simul_if_done got=%h exp=%h", {if_done, mem_done, if_rdata},
                           {2'b10, 32'h0000_0013}); end
    checks++; if (mem_rdata !== 32'h1111_2222) begin
      failures++; $display("FAIL simul_mem_rdata_held got=%h exp=11112222", mem_rdata); end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    logic [7:0] order;  // bit i = 1 when grant i went to fetch
    int grants;
    order = '0; grants = 0;
    if_req = 1'b1; if_addr = 32'h4000;
    mem_req = 1'b1; mem_addr = 32'h3000; mem_sel = 4'h3;
    bus_ack = 1'b1; bus_rdata = 32'h5;   // ack also held through IDLE/RESP
    for (int c = 0; c < 40 && grants < 6; c++) begin
      tick();
      if (bus_req) begin
        order[grants] = (bus_addr == 32'h4000);
        grants++;
      end
    end
    checks++; if (grants !== 6) begin
      failures++; $display("FAIL starve_grants got=%0d exp=6", grants); end
    checks++; if (order[5:0] !== 6'b010000) begin
      failures++; $display("FAIL starve_order got=%b exp=010000", order[5:0]); end
    if_req = 1'b0; mem_req = 1'b0;
    tick(); tick(); tick();
    bus_ack = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int cyc;
    cyc = 0;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h50; mem_sel = 4'hF;
    tick(); cyc++;
    mem_req = 1'b0;                      // drop mid-access; access must still finish
    while (!mem_done && cyc < 400) begin
      tick(); cyc++;
    end
    checks++; if (cyc !== 256) begin
      failures++; $display("FAIL timeout_latency got=%0d exp=256", cyc); end
    checks++; if ({mem_done, bus_err, if_done} !== 3'b110) begin
      failures++; $display("FAIL timeout_flags got=%b exp=110", {mem_done, bus_err, if_done}); end
    checks++; if (mem_rdata !== 32'd0) begin
      failures++; $display("FAIL timeout_rdata got=%h exp=0", mem_rdata); end
    tick();
    checks++; if ({mem_done, bus_err} !== 2'b00) begin
      failures++; $display("FAIL timeout_pulse got=%b exp=00", {mem_done, bus_err}); end
  endtask

  task automatic test_wait_states();
    int early;
    early = 0;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h40;              // cycle 0
    for (int c = 1; c <= 4; c++) begin
      tick();                                                      // cycles 1..4
      if (mem_done || !bus_req) early++;
      if (c == 4) begin bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D; end
    end
    tick();                                                        // cycle 5
    bus_ack = 1'b0;
    checks++; if (early !== 0) begin
      failures++; $display("FAIL wait_early got=%0d exp=0", early); end
    checks++; if ({mem_done, bus_err, mem_rdata} !== {2'b10, 32'hCAFE_F00D}) begin
      failures++; $display("FAIL wait_done got=%h exp=%h", {mem_done, bus_err, mem_rdata},
                           {2'b10, 32'hCAFE_F00D}); end
    mem_req = 1'b0;
    tick();
  endtask

  task automatic test_mid_reset();
    int spurious;
    spurious = 0;
    if_req = 1'b1; if_addr = 32'h200; mem_req = 1'b1; mem_addr = 32'h60;  // cycle 0
    tick();                                                              // cycle 1
    checks++; if ({bus_req, bus_addr} !== {1'b1, 32'h60}) begin
      failures++; $display("FAIL midrst_acc got=%h exp=%h", {bus_req, bus_addr}, {1'b1, 32'h60}); end
    tick();                                                              // cycle 2
    rst = 1'b1; if_req = 1'b0; mem_req = 1'b0; bus_ack = 1'b1;
    tick();                                                              // cycle 3
    rst = 1'b0; bus_ack = 1'b0;
    checks++; if (bus_req !== 1'b0) begin
      failures++; $display("FAIL midrst_bus_req got=%b exp=0", bus_req); end
    checks++; if ({dut.wait_cnt, dut.starve_cnt} !== 12'd0) begin
      failures++; $display("FAIL midrst_counters got=%h exp=0", {dut.wait_cnt, dut.starve_cnt}); end
    for (int c = 0; c < 5; c++) begin
      tick();
      if (mem_done || if_done || bus_req) spurious++;
    end
    checks++; if (spurious !== 0) begin
      failures++; $display("FAIL midrst_no_done got=%0d exp=0", spurious); end
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_wait_states();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
